// File: rtl/mem_wait_responder.sv
// Byte-addressed memory responder on a req/ack handshake with LATENCY wait states.
// Supports word/half/byte access, little-endian, and rejects misaligned requests.
module mem_wait_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        misalign
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_busy;
    logic                r_misalign;
    logic [7:0]          r_mem [DEPTH];

    logic                w_is_word;
    logic                w_is_half;
    logic                w_misaligned;
    logic                w_access;
    logic [ADDR_W-1:0]   w_a [4];
    logic [7:0]          w_lane_wd [4];
    logic [3:0]          w_lane_we;
    logic [31:0]         w_rd_word;
    logic                w_unused_addr;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign w_unused_addr = ^addr[31:ADDR_W];

    assign w_is_word    = (r_size == 2'b00) || (r_size == 2'b11);
    assign w_is_half    = (r_size == 2'b01);
    assign w_misaligned = (w_is_word && (r_addr[1:0] != 2'b00)) ||
                          (w_is_half && r_addr[0]);
    assign w_access     = (r_state == S_WAIT) && (r_cnt == 4'd0) && !w_misaligned;

    // Lane 0 is written for every size, lane 1 for half/word, lanes 2-3 for word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_a[gi]       = r_addr + ADDR_W'(gi);
            assign w_lane_wd[gi] = r_wdata[8*gi +: 8];
            assign w_lane_we[gi] = w_access && r_wr &&
                                   (w_is_word || (w_is_half && (gi < 2)) || (gi == 0));
        end
    endgenerate

    always_comb begin
        w_rd_word = {24'b0, r_mem[w_a[0]]};
        if (w_is_word)
            w_rd_word = {r_mem[w_a[3]], r_mem[w_a[2]], r_mem[w_a[1]], r_mem[w_a[0]]};
        else if (w_is_half)
            w_rd_word = {16'b0, r_mem[w_a[1]], r_mem[w_a[0]]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_lane_we[i]) r_mem[w_a[i]] <= w_lane_wd[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_wr    <= wr;
                        r_addr  <= addr[ADDR_W-1:0];
                        r_size  <= size;
                        r_wdata <= wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_RESP;
                        r_ack      <= 1'b1;
                        r_misalign <= w_misaligned;
                        if (!w_misaligned && !r_wr) r_rdata <= w_rd_word;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_ack      <= 1'b0;
                    r_busy     <= 1'b0;
                    r_misalign <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign misalign = r_misalign;
endmodule

// File: tb/tb_mem_wait_responder.sv
// Randomized scoreboard bench for mem_wait_responder: two instances (LATENCY 2 and 1)
// share the stimulus bus; a byte-array reference model predicts each response.
module tb_mem_wait_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [1:0]  ack_w;
    logic [1:0]  busy_w;
    logic [1:0]  mis_w;
    logic [31:0] rd0;
    logic [31:0] rd1;

    always #5 clk = ~clk;

    mem_wait_responder #(.ADDR_W(8), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(rst), .req(req & ~sel), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .rdata(rd0), .ack(ack_w[0]), .busy(busy_w[0]), .misalign(mis_w[0]));

    mem_wait_responder #(.ADDR_W(8), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(rst), .req(req & sel), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .rdata(rd1), .ack(ack_w[1]), .busy(busy_w[1]), .misalign(mis_w[1]));

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          acc;
        logic        wr;
        logic [31:0] addr;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mem_m [2][256];
    logic [31:0] last_rd [2];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          run [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem_m[k][i] = 8'h00;
            last_rd[k] = 32'h0;
        end
    endtask

    // Reference behaviour: alignment rule, little-endian byte storage, sticky read data.
    task automatic model_op(input int k, input logic w, input logic [31:0] ad,
                            input logic [1:0] sz, input int acc);
        int a, nb;
        logic word, half, m;
        logic [31:0] rd;
        exp_t e;
        a    = int'(ad[7:0]);
        word = (sz == 2'd0) || (sz == 2'd3);
        half = (sz == 2'd1);
        nb   = word ? 4 : (half ? 2 : 1);
        m    = (word && (a % 4 != 0)) || (half && (a % 2 != 0));
        if (!m) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mem_m[k][a+i] = wdata[8*i +: 8];
            end else begin
                rd = 32'h0;
                for (int i = 0; i < nb; i++) rd = rd | (32'(mem_m[k][a+i]) << (8*i));
                last_rd[k] = rd;
            end
        end
        e.rdata = last_rd[k];
        e.mis   = m;
        e.acc   = acc;
        e.wr    = w;
        e.addr  = ad;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_one(input int k);
        exp_t e;
        int lat, qs;
        logic [31:0] rd;
        run[k] = busy_w[k] ? run[k] + 1 : 0;
        if (ack_w[k]) begin
            qs = (k == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++;
                $display("FAIL unexpected_ack dut%0d: got ack=1 expected ack=0 at cycle %0d", k, cyc);
            end else begin
                e   = (k == 0) ? q0.pop_front() : q1.pop_front();
                lat = (k == 0) ? LAT0 : LAT1;
                rd  = (k == 0) ? rd0 : rd1;
                $display("dut%0d txn wr=%0d addr=%h rdata=%h misalign=%0d cycle=%0d",
                         k, e.wr, e.addr, rd, mis_w[k], cyc);
                check($sformatf("rdata dut%0d addr %h", k, e.addr), rd, e.rdata);
                check($sformatf("misalign dut%0d addr %h", k, e.addr), 32'(mis_w[k]), 32'(e.mis));
                check($sformatf("ack_latency dut%0d", k), 32'(cyc), 32'(e.acc + lat));
                check($sformatf("busy_cycles dut%0d", k), 32'(run[k]), 32'(lat + 1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run[0] = 0;
            run[1] = 0;
        end else begin
            mon_one(0);
            mon_one(1);
        end
    end

    task automatic wait_ack(input int k);
        int n = 0;
        while (!ack_w[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ack_w[k]) begin
            checks++;
            $display("FAIL ack_timeout dut%0d: got no ack expected ack within 40 cycles", k);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_w[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input int k, input logic w, input logic [31:0] ad,
                         input logic [1:0] sz, input logic [31:0] wd);
        @(negedge clk);
        wait_idle(k);
        sel = (k == 1); wr = w; addr = ad; size = sz; wdata = wd; req = 1'b1;
        model_op(k, w, ad, sz, cyc + 1);
        @(posedge clk);
        #1 req = 1'b0;
        wait_ack(k);
    endtask

    initial begin
        int acc;
        rst = 1'b1; req = 1'b0; wr = 1'b0; sel = 1'b0;
        addr = 32'h0; size = 2'b00; wdata = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_ack dut%0d", k), 32'(ack_w[k]), 32'h0);
            check($sformatf("reset_busy dut%0d", k), 32'(busy_w[k]), 32'h0);
            check($sformatf("reset_misalign dut%0d", k), 32'(mis_w[k]), 32'h0);
        end
        check("reset_rdata dut0", rd0, 32'h0);
        check("reset_rdata dut1", rd1, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word write/read, byte merge, half read, misaligned read, re-read.
        issue(0, 1'b1, 32'h10, 2'b00, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 2'b00, 32'h0);
        issue(0, 1'b1, 32'h11, 2'b10, 32'h000000A5);
        issue(0, 1'b0, 32'h10, 2'b01, 32'h0);
        issue(0, 1'b0, 32'h10, 2'b00, 32'h0);
        issue(0, 1'b0, 32'h12, 2'b00, 32'h0);
        issue(0, 1'b0, 32'h10, 2'b00, 32'h0);

        // req pulsed in WAIT is ignored; req held through ack is taken at E_(LATENCY+2).
        @(negedge clk);
        wait_idle(0);
        sel = 1'b0; wr = 1'b0; addr = 32'h10; size = 2'b00; req = 1'b1;
        acc = cyc + 1;
        model_op(0, 1'b0, 32'h10, 2'b00, acc);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk); req = 1'b1;
        model_op(0, 1'b0, 32'h10, 2'b00, acc + LAT0 + 2);
        repeat (3) @(posedge clk);
        #1 req = 1'b0;
        wait_ack(0);

        // Reset during WAIT of a write: aborted, outputs clear at once, storage cleared.
        @(negedge clk);
        wait_idle(0);
        sel = 1'b0; wr = 1'b1; addr = 32'h20; size = 2'b00; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ack", 32'(ack_w[0]), 32'h0);
        check("abort_busy", 32'(busy_w[0]), 32'h0);
        check("abort_rdata", rd0, 32'h0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(0, 1'b0, 32'h20, 2'b00, 32'h0);

        // Address wrap on both latencies.
        issue(0, 1'b1, 32'hFFFFFF04, 2'b00, 32'h0BADF00D);
        issue(0, 1'b0, 32'h00000004, 2'b00, 32'h0);
        issue(1, 1'b1, 32'hFFFFFF04, 2'b00, 32'h0BADF00D);
        issue(1, 1'b0, 32'h00000004, 2'b00, 32'h0);

        for (int i = 0; i < 120; i++) begin
            int k;
            logic w;
            logic [31:0] ad;
            logic [1:0] sz;
            k  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad[7:0] = 8'($urandom_range(0, 31));
            sz = 2'($urandom_range(0, 3));
            issue(k, w, ad, sz, $urandom);
        end

        repeat (6) @(negedge clk);
        check("queue0_drained", 32'(q0.size()), 32'h0);
        check("queue1_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
